// File: rtl/pipe_stage_buf_if.sv
// ============================================================================
// Module      : pipe_stage_buf_if
// Description : valid/ready payload channel (data + control) between stages.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface pipe_stage_buf_if #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input  ready);
  modport slave  (input  valid, input  data, input  ctrl, output ready);
endinterface

`default_nettype wire

// File: rtl/pipe_stage_buf.sv
// ============================================================================
// Module      : pipe_stage_buf
// Description : two-entry (main + skid) pipeline stage register with flush
//               and saturating stall-cycle counter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pipe_stage_buf #(
  parameter int DATA_W     = 64,
  parameter int CTRL_W     = 16,
  parameter int CNT_W      = 16,
  parameter bit CLEAR_DATA = 1'b0
) (
  input  wire logic             CLK,
  input  wire logic             nRST,
  input  wire logic             flush,
  pipe_stage_buf_if.slave       up,
  pipe_stage_buf_if.master      dn,
  output logic [1:0]            occupancy,
  output logic [CNT_W-1:0]      stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q,     state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic in_fire;
  logic out_fire;

  // Ready depends only on stored state, so no combinational path from dn.ready.
  assign up.ready  = (state_q != FULL);
  assign dn.valid  = (state_q != EMPTY);
  assign dn.data   = main_data_q;
  assign dn.ctrl   = dn.valid ? main_ctrl_q : '0;
  assign occupancy = state_q;
  assign stall_cnt = stall_cnt_q;

  assign in_fire  = up.valid & up.ready;
  assign out_fire = dn.valid & dn.ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    stall_cnt_d = stall_cnt_q;

    if (dn.valid && !dn.ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end

    if (flush) begin
      state_d     = EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      if (CLEAR_DATA) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_data_d = up.data;
            main_ctrl_d = up.ctrl;
            state_d     = HALF;
          end
        end
        HALF: begin
          if (in_fire && out_fire) begin
            main_data_d = up.data;
            main_ctrl_d = up.ctrl;
          end else if (in_fire) begin
            skid_data_d = up.data;
            skid_ctrl_d = up.ctrl;
            state_d     = FULL;
          end else if (out_fire) begin
            main_ctrl_d = '0;
            state_d     = EMPTY;
          end
        end
        FULL: begin
          if (dn.ready) begin
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            skid_ctrl_d = '0;
            state_d     = HALF;
          end
        end
        default: begin
          state_d     = EMPTY;
          main_ctrl_d = '0;
          skid_ctrl_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised inter-stage pipeline register for the five-stage core. It generalises the fixed-field stage latch into a generic payload buffer.
- Two entries: a main register plus a skid register.
- valid/ready handshake on both sides.
- Synchronous flush that turns the stage into a bubble.
- Saturating stall-cycle counter for performance debug.
Sits between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Upstream in_ready is a pure function of stored state, which breaks the combinational stall path through the pipe.

Parameters:
DATA_W, 64, width of datapath payload (PC, ALU result, operands, register indices); bits held across flush.
CTRL_W, 16, width of control payload (regWEN, dMemWEN, dMemREN, Halt, ...); bits forced to 0 on flush and bubble.
CNT_W, 16, width of the stall counter.
CLEAR_DATA, 0, 1 = data bits of both entries zeroed on flush; 0 = data bits held on flush.

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  synchronous active-low reset
flush  in  1  discard all stored entries this cycle
in_valid  in  1  upstream offers an entry
in_ready  out  1  buffer accepts an entry; equals (state != FULL)
in_data  in  DATA_W  upstream data payload
in_ctrl  in  CTRL_W  upstream control payload
out_valid  out  1  main entry valid; equals (state != EMPTY)
out_ready  in  1  downstream consumes the main entry
out_data  out  DATA_W  main entry data
out_ctrl  out  CTRL_W  main entry control; 0 whenever out_valid = 0
occupancy  out  2  entries held: 0, 1 or 2
stall_cnt  out  CNT_W  cycles with out_valid & !out_ready, saturating

Behaviour:
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. All register updates occur on the rising CLK edge.
- Reset (nRST = 0 at an edge): state EMPTY; main and skid registers (data and ctrl) cleared to 0; stall_cnt cleared to 0.
- Values after the reset edge: out_valid=0, out_data=0, out_ctrl=0, in_ready=1, occupancy=0, stall_cnt=0.
- Reset has priority over flush and over any handshake.
- State machine (occupancy = 0/1/2 for EMPTY/HALF/FULL):
  - EMPTY, in_fire: main <= in, go to HALF.
  - EMPTY, no in_fire: stay EMPTY.
  - HALF, in_fire & out_fire: main <= in, stay HALF (pass-through, 1 entry/cycle).
  - HALF, in_fire & !out_ready: skid <= in, go to FULL.
  - HALF, out_fire & !in_fire: main ctrl <= 0, go to EMPTY.
  - HALF, otherwise: hold.
  - FULL, out_ready: main <= skid, skid ctrl <= 0, go to HALF. in_ready = 0 in FULL, so no input is taken.
  - FULL, !out_ready: hold; in_ready stays 0.
- Latency: an entry accepted at edge N is on out_* after edge N. Throughput is 1 entry/cycle when out_ready stays high.
- Ordering: strictly FIFO; the skid entry always leaves after the main entry.
- Flush (nRST=1, flush=1), evaluated before all handshakes:
  - state -> EMPTY; ctrl of main and skid <= 0.
  - Data of both entries <= 0 if CLEAR_DATA=1, else held.
  - An in_fire in the same cycle is dropped. An out_fire in the same cycle still counts as consumed by downstream.
- Bubble rule: out_ctrl must never carry nonzero bits while out_valid = 0. This guarantees no spurious regWEN/dMemWEN downstream.
- stall_cnt: +1 on each edge where out_valid & !out_ready, evaluated before the state update. Saturates at 2^CNT_W-1. Unaffected by flush; cleared only by reset.
- Payload is never modified in flight; widths pass through unchanged.
- Reset mid-operation (state FULL, stall_cnt nonzero): all cleared at the reset edge. No entry emerges afterwards.

Test Plan:
- Reset, then in_valid=1 every cycle with data 1,2,3,4 and out_ready=1 -> out_data 1,2,3,4 on consecutive cycles, each one cycle after acceptance; occupancy stays 1; stall_cnt=0.
- Accept A=0x11, hold out_ready=0, offer B=0x22 -> occupancy 2, in_ready=0, stall_cnt increments each cycle. Raise out_ready -> A then B emerge in order; in_ready returns to 1 the cycle after FULL exits.
- State FULL with in_ctrl=0xFFFF entries, assert flush for one cycle, CLEAR_DATA=0 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, out_data still the old main data. With CLEAR_DATA=1 -> out_data=0.
- flush and in_valid (data 0x55) together from state EMPTY -> entry dropped; out_valid remains 0 on following cycles.
- CNT_W=4, out_valid=1 with out_ready=0 for 20 cycles -> stall_cnt saturates at 15. Assert flush -> stall_cnt remains 15. Assert nRST=0 -> stall_cnt=0.
- nRST=0 for one edge while FULL -> all outputs at reset values next cycle, in_ready=1. No stale entry appears after nRST returns to 1.
